root_req_arbiter: RTL and testbench

//  Shares one Root engine (10-bit radicand, 3-bit exponent, 20-bit 10.10 result) among NREQ requesters.

---
 rtl/root_pkg.sv | 16 +
 rtl/rr_picker.sv | 30 +++
 rtl/root_req_arbiter.sv | 158 +++++++++++++++
 tb/tb_root_req_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/root_pkg.sv
// rtl/root_pkg.sv - shared widths and FSM encoding for the root engine arbiter
package root_pkg;

    localparam int RADICAND_W = 10;
    localparam int EXP_W      = 3;
    localparam int RESULT_W   = 20;   // 10.10 fixed point

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RECOVER,
        ST_RESP
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin one-hot pick starting at rr_ptr
module rr_picker #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant_onehot,
    output logic [IDW-1:0]  grant_id,
    output logic            any
);

    logic [IDW-1:0] idx;

    always_comb begin
        grant_onehot = '0;
        grant_id     = '0;
        any          = 1'b0;
        idx          = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!any && req_valid[idx]) begin
                any               = 1'b1;
                grant_onehot[idx] = 1'b1;
                grant_id          = idx;
            end
        end
    end

endmodule

// File: rtl/root_req_arbiter.sv
// rtl/root_req_arbiter.sv - round-robin sharing of one root engine with watchdog recovery
module root_req_arbiter
    import root_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int TIMEOUT = 255,
    parameter  int TW      = 8,
    parameter  int RST_CYC = 2,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*RADICAND_W-1:0] req_data_1,
    input  logic [NREQ*EXP_W-1:0]      req_data_2,
    output logic                       eng_rst_n,
    output logic                       eng_in_valid,
    output logic [RADICAND_W-1:0]      eng_in_data_1,
    output logic [EXP_W-1:0]           eng_in_data_2,
    input  logic                       eng_out_valid,
    input  logic [RESULT_W-1:0]        eng_out_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [IDW-1:0]             rsp_id,
    output logic [RESULT_W-1:0]        rsp_data,
    output logic                       rsp_err
);

    localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    state_t                state_q, state_d;
    logic [IDW-1:0]        rr_ptr_q, id_q;
    logic [RADICAND_W-1:0] data_1_q;
    logic [EXP_W-1:0]      data_2_q;
    logic [RESULT_W-1:0]   rsp_data_q;
    logic                  rsp_err_q;
    logic [TW-1:0]         wd_cnt_q;
    logic [RCW-1:0]        rc_cnt_q;

    logic [NREQ-1:0]       grant_onehot;
    logic [IDW-1:0]        grant_id;
    logic                  grant_any;
    logic [RADICAND_W-1:0] sel_data_1;
    logic [EXP_W-1:0]      sel_data_2;
    logic                  wd_expired, rc_done, exp_zero;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req_valid    (req_valid),
        .rr_ptr       (rr_ptr_q),
        .grant_onehot (grant_onehot),
        .grant_id     (grant_id),
        .any          (grant_any)
    );

    always_comb begin
        sel_data_1 = '0;
        sel_data_2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_onehot[i]) begin
                sel_data_1 = req_data_1[i*RADICAND_W +: RADICAND_W];
                sel_data_2 = req_data_2[i*EXP_W +: EXP_W];
            end
        end
    end

    assign exp_zero   = (sel_data_2 == '0);
    assign wd_expired = (wd_cnt_q == TW'(TIMEOUT));
    assign rc_done    = (rc_cnt_q == RCW'(RST_CYC - 1));

    // Strobes are gated by rst so the reset cycle itself shows the idle values.
    always_comb begin
        state_d      = state_q;
        req_ready    = '0;
        eng_in_valid = 1'b0;
        eng_rst_n    = !rst;
        rsp_valid    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = rst ? '0 : grant_onehot;
                if (grant_any) state_d = exp_zero ? ST_RESP : ST_ISSUE;
            end
            ST_ISSUE: begin
                eng_in_valid = !rst;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_out_valid)   state_d = ST_RESP;
                else if (wd_expired) state_d = ST_RECOVER;
            end
            ST_RECOVER: begin
                eng_rst_n = 1'b0;
                if (rc_done) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = !rst;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            id_q       <= '0;
            data_1_q   <= '0;
            data_2_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            wd_cnt_q   <= '0;
            rc_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (grant_any) begin
                        id_q     <= grant_id;
                        data_1_q <= sel_data_1;
                        data_2_q <= sel_data_2;
                        if (exp_zero) begin
                            rsp_data_q <= '0;
                            rsp_err_q  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: wd_cnt_q <= '0;
                ST_WAIT: begin
                    wd_cnt_q <= wd_cnt_q + 1'b1;
                    rc_cnt_q <= '0;
                    if (eng_out_valid) begin
                        rsp_data_q <= eng_out_data;
                        rsp_err_q  <= 1'b0;
                    end
                end
                ST_RECOVER: begin
                    rc_cnt_q <= rc_cnt_q + 1'b1;
                    if (rc_done) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) rr_ptr_q <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign eng_in_data_1 = data_1_q;
    assign eng_in_data_2 = data_2_q;
    assign rsp_id        = id_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_root_req_arbiter.sv
// tb/tb_root_req_arbiter.sv - randomized self-checking bench for root_req_arbiter
module tb_root_req_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 40;
    localparam int TW      = 8;
    localparam int RST_CYC = 2;
    localparam int IDW     = $clog2(NREQ);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*10-1:0] req_data_1 = '0;
    logic [NREQ*3-1:0] req_data_2 = '0;
    logic              eng_rst_n, eng_in_valid;
    logic [9:0]        eng_in_data_1;
    logic [2:0]        eng_in_data_2;
    logic              eng_out_valid = 1'b0;
    logic [19:0]       eng_out_data = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic [19:0]       rsp_data;
    logic              rsp_err;

    root_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW), .RST_CYC(RST_CYC)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data_1    (req_data_1),
        .req_data_2    (req_data_2),
        .eng_rst_n     (eng_rst_n),
        .eng_in_valid  (eng_in_valid),
        .eng_in_data_1 (eng_in_data_1),
        .eng_in_data_2 (eng_in_data_2),
        .eng_out_valid (eng_out_valid),
        .eng_out_data  (eng_out_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // stimulus knobs
    int p_req = 0, p_ready = 100, p_exp0 = 0, p_hang = 0, p_stray = 0, fix_lat = 0;
    bit hold_all = 0, force_hang = 0, rst_req = 1;
    bit         inj_v  [NREQ];
    logic [9:0] inj_d1 [NREQ];
    logic [2:0] inj_d2 [NREQ];
    logic [NREQ-1:0] accepted = '0;

    // transaction-level reference: one outstanding job, rr pointer, expected response
    int          m_ptr = 0;
    bit          job_open = 0, hang_job = 0, exp_err = 0, post_rst = 0;
    int          job_id = 0, acc_cyc = 0, exp_rsp_cyc = -1;
    logic [9:0]  job_d1 = '0;
    logic [2:0]  job_d2 = '0;
    logic [19:0] exp_data = '0;

    // engine model
    bit          eng_busy = 0;
    int          eng_due = -1;
    logic [9:0]  eng_r = '0;
    logic [2:0]  eng_e = '0;

    int          n_issue = 0, n_rsp = 0, last_id = 0;
    logic [19:0] last_data = '0;
    bit          last_err = 0;
    int          grant_log[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [19:0] root_fn(input logic [9:0] r, input logic [2:0] e);
        real v;
        if (e == 3'd0) return '0;
        if (e == 3'd2) v = $sqrt($itor(r));
        else           v = $pow($itor(r), 1.0 / $itor(e));
        return 20'($rtoi(v * 1024.0));
    endfunction

    task automatic drive();
        rst = rst_req;
        req_valid = req_valid & ~accepted;
        accepted  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i]) begin
                if (inj_v[i]) begin
                    req_valid[i] = 1'b1;
                    req_data_1[i*10 +: 10] = inj_d1[i];
                    req_data_2[i*3 +: 3]   = inj_d2[i];
                    inj_v[i] = 1'b0;
                end else if (hold_all || int'($urandom_range(99)) < p_req) begin
                    req_valid[i] = 1'b1;
                    req_data_1[i*10 +: 10] = 10'($urandom);
                    req_data_2[i*3 +: 3]   = (int'($urandom_range(99)) < p_exp0) ? 3'd0 : 3'($urandom_range(7, 1));
                end
            end
        end
        rsp_ready = int'($urandom_range(99)) < p_ready;
        if (eng_busy && cyc == eng_due) begin
            eng_out_valid = 1'b1;
            eng_out_data  = root_fn(eng_r, eng_e);
        end else if (!eng_busy && int'($urandom_range(99)) < p_stray) begin
            eng_out_valid = 1'b1;
            eng_out_data  = 20'($urandom);
        end else begin
            eng_out_valid = 1'b0;
            eng_out_data  = 20'($urandom);
        end
    endtask

    task automatic monitor();
        int pred;
        int g;
        logic [NREQ-1:0] exp_ready;
        logic exp_iv, exp_rn, exp_rv;
        if (rst) begin
            check_eq("rst_req_ready", req_ready, '0);
            check_eq("rst_eng_in_valid", eng_in_valid, 0);
            check_eq("rst_eng_rst_n", eng_rst_n, 0);
            check_eq("rst_rsp_valid", rsp_valid, 0);
            job_open = 0; m_ptr = 0; eng_busy = 0; post_rst = 1;
            return;
        end
        if (post_rst) begin
            check_eq("rstval_rsp_id", rsp_id, 0);
            check_eq("rstval_rsp_data", rsp_data, 0);
            check_eq("rstval_rsp_err", rsp_err, 0);
            check_eq("rstval_eng_in_data_1", eng_in_data_1, 0);
            check_eq("rstval_eng_in_data_2", eng_in_data_2, 0);
            post_rst = 0;
        end
        pred = -1;
        if (!job_open)
            for (int k = 0; k < NREQ; k++)
                if (pred < 0 && req_valid[(m_ptr + k) % NREQ]) pred = (m_ptr + k) % NREQ;
        exp_ready = (pred >= 0) ? (NREQ'(1) << pred) : '0;
        check_eq("req_ready", req_ready, exp_ready);

        if (eng_out_valid && eng_busy) begin
            check_eq("eng_in_data_1_hold", eng_in_data_1, job_d1);
            check_eq("eng_in_data_2_hold", eng_in_data_2, job_d2);
            exp_rsp_cyc = cyc + 1;
            eng_busy = 0;
        end

        exp_rn = !(job_open && hang_job && cyc >= acc_cyc + 3 + TIMEOUT
                   && cyc <= acc_cyc + 2 + TIMEOUT + RST_CYC);
        check_eq("eng_rst_n", eng_rst_n, exp_rn);
        if (!eng_rst_n) eng_busy = 0;

        exp_iv = job_open && job_d2 != 3'd0 && cyc == acc_cyc + 1;
        check_eq("eng_in_valid", eng_in_valid, exp_iv);
        if (eng_in_valid) begin
            n_issue++;
            check_eq("eng_in_data_1", eng_in_data_1, job_d1);
            check_eq("eng_in_data_2", eng_in_data_2, job_d2);
            eng_busy = 1; eng_r = eng_in_data_1; eng_e = eng_in_data_2;
            if (force_hang || int'($urandom_range(99)) < p_hang) begin
                hang_job = 1; eng_due = -1;
                exp_rsp_cyc = acc_cyc + 3 + TIMEOUT + RST_CYC;
                exp_data = '0; exp_err = 1;
            end else begin
                eng_due = cyc + ((fix_lat > 0) ? fix_lat : int'($urandom_range(6, 1)));
            end
        end

        exp_rv = job_open && exp_rsp_cyc >= 0 && cyc >= exp_rsp_cyc;
        check_eq("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv) begin
            check_eq("rsp_id", rsp_id, job_id);
            check_eq("rsp_data", rsp_data, exp_data);
            check_eq("rsp_err", rsp_err, exp_err);
            if (rsp_ready) begin
                n_rsp++; last_id = job_id; last_data = exp_data; last_err = exp_err;
                m_ptr = (job_id + 1) % NREQ;
                job_open = 0;
            end
        end
        if (job_open && exp_rsp_cyc < 0 && cyc - acc_cyc == TIMEOUT + RST_CYC + 40) begin
            check_eq("job_result_overdue_cycles", cyc - acc_cyc, TIMEOUT + RST_CYC);
            job_open = 0;
        end

        if (req_ready != '0) begin
            g = 0;
            for (int i = NREQ - 1; i >= 0; i--) if (req_ready[i]) g = i;
            job_open = 1; job_id = g; acc_cyc = cyc; hang_job = 0;
            job_d1 = req_data_1[g*10 +: 10];
            job_d2 = req_data_2[g*3 +: 3];
            if (job_d2 == 3'd0) begin
                exp_rsp_cyc = cyc + 1; exp_data = '0; exp_err = 1;
            end else begin
                exp_rsp_cyc = -1; exp_data = root_fn(job_d1, job_d2); exp_err = 0;
            end
            accepted[g] = 1'b1;
            grant_log.push_back(g);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        drive();
        @(negedge clk);
        monitor();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic inject(input int i, input logic [9:0] d1, input logic [2:0] d2);
        inj_v[i] = 1'b1; inj_d1[i] = d1; inj_d2[i] = d2;
    endtask

    initial begin
        int n0, i0;
        for (int i = 0; i < NREQ; i++) inj_v[i] = 1'b0;
        rst_req = 1;
        run(2);
        rst_req = 0;
        run(2);

        // single job: sqrt(16) = 4.0
        fix_lat = 3; n0 = n_rsp; i0 = n_issue;
        inject(0, 10'd16, 3'd2);
        run(20);
        check_eq("t1_issues", n_issue - i0, 1);
        check_eq("t1_rsps", n_rsp - n0, 1);
        check_eq("t1_id", last_id, 0);
        check_eq("t1_data", last_data, 20'h01000);
        check_eq("t1_err", last_err, 0);

        // exponent zero is rejected without touching the engine
        n0 = n_rsp; i0 = n_issue;
        inject(2, 10'd55, 3'd0);
        run(10);
        check_eq("t3_issues", n_issue - i0, 0);
        check_eq("t3_id", last_id, 2);
        check_eq("t3_err", last_err, 1);
        check_eq("t3_data", last_data, 0);

        // hung engine then a normal job
        force_hang = 1; n0 = n_rsp;
        inject(1, 10'd100, 3'd3);
        run(TIMEOUT + RST_CYC + 10);
        force_hang = 0;
        check_eq("t4_rsps", n_rsp - n0, 1);
        check_eq("t4_id", last_id, 1);
        check_eq("t4_err", last_err, 1);
        inject(3, 10'd81, 3'd2);
        run(20);
        check_eq("t4_next_data", last_data, 20'h02400);
        check_eq("t4_next_err", last_err, 0);

        // back-pressure
        p_ready = 0; n0 = n_rsp;
        inject(0, 10'd200, 3'd1); inject(1, 10'd300, 3'd2); inject(2, 10'd400, 3'd3);
        run(15);
        check_eq("t5_held_rsps", n_rsp - n0, 0);
        p_ready = 100;
        run(40);
        check_eq("t5_rsps", n_rsp - n0, 3);

        // reset mid-WAIT abandons the job; stray strobes afterwards are ignored
        fix_lat = 20; n0 = n_rsp;
        inject(1, 10'd64, 3'd3);
        run(5);
        rst_req = 1; run(1); rst_req = 0;
        p_stray = 30;
        run(30);
        check_eq("t6_lost_rsps", n_rsp - n0, 0);
        fix_lat = 2;
        inject(3, 10'd9, 3'd2); inject(0, 10'd25, 3'd2);
        run(25);
        check_eq("t6_first_grant", grant_log[grant_log.size() - 2], 0);
        check_eq("t6_second_grant", grant_log[grant_log.size() - 1], 3);

        // round-robin with all requests held
        p_stray = 0;
        rst_req = 1; run(1); rst_req = 0;
        grant_log.delete();
        hold_all = 1; fix_lat = 1;
        run(40);
        hold_all = 0;
        if (grant_log.size() < 5) check_eq("t2_grant_count", grant_log.size(), 5);
        else begin
            check_eq("t2_g0", grant_log[0], 0);
            check_eq("t2_g1", grant_log[1], 1);
            check_eq("t2_g2", grant_log[2], 2);
            check_eq("t2_g3", grant_log[3], 3);
            check_eq("t2_g4", grant_log[4], 0);
        end

        // random traffic
        p_req = 25; p_ready = 70; p_exp0 = 15; p_hang = 3; p_stray = 10; fix_lat = 0;
        run(4000);
        p_req = 0; p_ready = 100; p_hang = 0;
        run(300);
        check_eq("drain_idle", job_open, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
